// File: rtl/active_list.sv
// active_list: in-order reorder/active list for register renaming with commit and flush rollback
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   alloc_valid/ready/tag             rename-stage allocation handshake; tag is the current tail
//   alloc_prev_phys/logical/new_phys  payload of the allocated entry
//   complete_valid/tag                marks an entry as executed
//   flush_valid/tag                   squash everything younger than flush_tag
//   free_valid/reg                    physical register returned to the free list
//   restore_valid/logical/phys        map-table rollback write
//   flush_done                        one-cycle pulse when rollback finishes
module active_list #(
   parameter int DEPTH = 32,
   parameter int PHYS_W = 6,
   parameter int LOG_W = 5,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [PHYS_W-1:0] alloc_prev_phys,
   input  logic [LOG_W-1:0]  alloc_logical,
   input  logic [PHYS_W-1:0] alloc_new_phys,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              complete_valid,
   input  logic [TAG_W-1:0]  complete_tag,
   input  logic              flush_valid,
   input  logic [TAG_W-1:0]  flush_tag,
   output logic              free_valid,
   output logic [PHYS_W-1:0] free_reg,
   output logic              restore_valid,
   output logic [LOG_W-1:0]  restore_logical,
   output logic [PHYS_W-1:0] restore_phys,
   output logic              flush_done
);
   typedef enum logic {NORMAL, ROLLBACK} state_t;
   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
   state_t state, state_next;
   logic [TAG_W-1:0] head, tail, tail_m1, stop;
   logic [TAG_W:0] count;
   logic [DEPTH-1:0] valid, done;
   logic [PHYS_W-1:0] prev_mem [DEPTH];
   logic [PHYS_W-1:0] new_mem [DEPTH];
   logic [LOG_W-1:0] log_mem [DEPTH];
   logic alloc_fire, commit, rb_step, rb_end, flush_take;
   always_comb begin
      tail_m1 = tail - 1'b1;
      alloc_ready = state == NORMAL && count != FULL;
      alloc_tag = tail;
      alloc_fire = alloc_valid && alloc_ready;
      commit = state == NORMAL && count != '0 && done[head];
      rb_step = state == ROLLBACK && tail_m1 != stop;
      rb_end = state == ROLLBACK && tail_m1 == stop;
      flush_take = flush_valid && state == NORMAL && valid[flush_tag];
      state_next = flush_take ? ROLLBACK : rb_end ? NORMAL : state;
      free_valid = commit || rb_step;
      free_reg = commit ? prev_mem[head] : rb_step ? new_mem[tail_m1] : '0;
      restore_valid = rb_step;
      restore_logical = rb_step ? log_mem[tail_m1] : '0;
      restore_phys = rb_step ? prev_mem[tail_m1] : '0;
      flush_done = rb_end;
   end
   // Later writes in this block override earlier ones, so a completion that
   // lands on the committing head is discarded along with the entry.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= NORMAL;
         head <= '0;
         tail <= '0;
         stop <= '0;
         count <= '0;
         valid <= '0;
         done <= '0;
      end else begin
         state <= state_next;
         count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, free_valid};
         if (complete_valid && valid[complete_tag]) done[complete_tag] <= 1'b1;
         if (commit) begin
            valid[head] <= 1'b0;
            done[head] <= 1'b0;
            head <= head + 1'b1;
         end
         if (alloc_fire) begin
            valid[tail] <= 1'b1;
            done[tail] <= 1'b0;
            tail <= tail + 1'b1;
         end
         if (rb_step) begin
            valid[tail_m1] <= 1'b0;
            done[tail_m1] <= 1'b0;
            tail <= tail_m1;
         end
         if (flush_take) stop <= flush_tag;
      end
   // Payload needs no reset: it is only read while the entry is valid.
   always_ff @(posedge clk)
      if (alloc_fire) begin
         prev_mem[tail] <= alloc_prev_phys;
         log_mem[tail] <= alloc_logical;
         new_mem[tail] <= alloc_new_phys;
      end
endmodule

// File: tb/tb_active_list.sv
// tb_active_list: directed scoreboard bench for active_list
module tb_active_list;
   logic clk, rst_n;
   logic alloc_valid, alloc_ready;
   logic [5:0] alloc_prev_phys, alloc_new_phys;
   logic [4:0] alloc_logical, alloc_tag;
   logic complete_valid, flush_valid;
   logic [4:0] complete_tag, flush_tag;
   logic free_valid, restore_valid, flush_done;
   logic [5:0] free_reg, restore_phys;
   logic [4:0] restore_logical;
   int checks = 0, fails = 0;
   int free_q[$], rl_q[$], rp_q[$];
   active_list dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_prev_phys(alloc_prev_phys), .alloc_logical(alloc_logical),
      .alloc_new_phys(alloc_new_phys), .alloc_tag(alloc_tag),
      .complete_valid(complete_valid), .complete_tag(complete_tag),
      .flush_valid(flush_valid), .flush_tag(flush_tag),
      .free_valid(free_valid), .free_reg(free_reg),
      .restore_valid(restore_valid), .restore_logical(restore_logical),
      .restore_phys(restore_phys), .flush_done(flush_done)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic alloc(input int p, input int l, input int n, input int t);
      alloc_valid = 1;
      alloc_prev_phys = 6'(p);
      alloc_logical = 5'(l);
      alloc_new_phys = 6'(n);
      chk("alloc_tag", 32'(alloc_tag), t);
      cyc();
      alloc_valid = 0;
   endtask
   task automatic complete(input int t);
      complete_valid = 1;
      complete_tag = 5'(t);
      cyc();
      complete_valid = 0;
   endtask
   task automatic flush(input int t);
      flush_valid = 1;
      flush_tag = 5'(t);
      cyc();
      flush_valid = 0;
   endtask
   task automatic do_reset();
      #1 rst_n = 0;
      #2 rst_n = 1;
      cyc();
   endtask
   // Scoreboard: every free/restore the DUT emits must match the next queued expectation.
   always @(negedge clk)
      if (rst_n) begin
         if (free_valid) begin
            chk("free_unexpected", 32'(free_q.size() != 0), 1);
            if (free_q.size() != 0) chk("free_reg_sb", 32'(free_reg), free_q.pop_front());
         end
         if (restore_valid) begin
            chk("restore_unexpected", 32'(rl_q.size() != 0), 1);
            if (rl_q.size() != 0) begin
               chk("restore_logical_sb", 32'(restore_logical), rl_q.pop_front());
               chk("restore_phys_sb", 32'(restore_phys), rp_q.pop_front());
            end
         end
      end
   initial begin
      rst_n = 0;
      alloc_valid = 0; alloc_prev_phys = 0; alloc_logical = 0; alloc_new_phys = 0;
      complete_valid = 0; complete_tag = 0; flush_valid = 0; flush_tag = 0;
      #12;
      chk("rst_free_valid", 32'(free_valid), 0);
      chk("rst_restore_valid", 32'(restore_valid), 0);
      chk("rst_flush_done", 32'(flush_done), 0);
      rst_n = 1;
      #1;
      chk("rst_alloc_ready", 32'(alloc_ready), 1);
      chk("rst_alloc_tag", 32'(alloc_tag), 0);
      cyc();
      // single alloc then completion: commit one cycle later
      alloc(3, 3, 32, 0);
      free_q.push_back(3);
      complete(0);
      chk("commit_valid", 32'(free_valid), 1);
      chk("commit_reg", 32'(free_reg), 3);
      cyc();
      chk("commit_count", 32'(dut.count), 0);
      chk("commit_idle", 32'(free_valid), 0);
      // out-of-order completion, in-order commit
      do_reset();
      alloc(10, 1, 50, 0);
      alloc(11, 2, 51, 1);
      complete(1);
      chk("ooo_no_commit0", 32'(free_valid), 0);
      cyc();
      chk("ooo_no_commit1", 32'(free_valid), 0);
      free_q.push_back(10);
      free_q.push_back(11);
      complete(0);
      chk("ooo_free0_valid", 32'(free_valid), 1);
      chk("ooo_free0_reg", 32'(free_reg), 10);
      cyc();
      chk("ooo_free1_valid", 32'(free_valid), 1);
      chk("ooo_free1_reg", 32'(free_reg), 11);
      cyc();
      chk("ooo_idle", 32'(free_valid), 0);
      chk("ooo_count", 32'(dut.count), 0);
      // fill to capacity, then commit one
      do_reset();
      for (int i = 0; i < 32; i++) alloc(i, i, 63 - i, i);
      chk("full_ready", 32'(alloc_ready), 0);
      chk("full_count", 32'(dut.count), 32);
      chk("full_tag_wrap", 32'(alloc_tag), 0);
      free_q.push_back(0);
      complete(0);
      chk("full_ready_during_commit", 32'(alloc_ready), 0);
      chk("full_commit_valid", 32'(free_valid), 1);
      cyc();
      chk("full_ready_after", 32'(alloc_ready), 1);
      chk("full_count_after", 32'(dut.count), 31);
      alloc(7, 7, 7, 0);
      chk("full_again", 32'(alloc_ready), 0);
      // flush tag1 out of four entries
      do_reset();
      for (int i = 0; i < 4; i++) alloc(20 + i, i + 1, 40 + i, i);
      rl_q.push_back(4); rp_q.push_back(23); free_q.push_back(43);
      rl_q.push_back(3); rp_q.push_back(22); free_q.push_back(42);
      flush(1);
      chk("rb1_restore_valid", 32'(restore_valid), 1);
      chk("rb1_restore_logical", 32'(restore_logical), 4);
      chk("rb1_restore_phys", 32'(restore_phys), 23);
      chk("rb1_free_reg", 32'(free_reg), 43);
      chk("rb1_alloc_ready", 32'(alloc_ready), 0);
      chk("rb1_flush_done", 32'(flush_done), 0);
      cyc();
      chk("rb2_restore_logical", 32'(restore_logical), 3);
      chk("rb2_free_reg", 32'(free_reg), 42);
      cyc();
      chk("rb3_flush_done", 32'(flush_done), 1);
      chk("rb3_restore_valid", 32'(restore_valid), 0);
      chk("rb3_free_valid", 32'(free_valid), 0);
      cyc();
      chk("rb_done_pulse", 32'(flush_done), 0);
      chk("rb_alloc_ready", 32'(alloc_ready), 1);
      chk("rb_count", 32'(dut.count), 2);
      chk("rb_alloc_tag", 32'(alloc_tag), 2);
      // flush of the youngest entry
      flush(1);
      chk("young_flush_done", 32'(flush_done), 1);
      chk("young_restore", 32'(restore_valid), 0);
      chk("young_free", 32'(free_valid), 0);
      cyc();
      chk("young_done_pulse", 32'(flush_done), 0);
      chk("young_count", 32'(dut.count), 2);
      // flush of an invalid entry is ignored
      flush(9);
      chk("bad_flush_restore", 32'(restore_valid), 0);
      chk("bad_flush_done", 32'(flush_done), 0);
      chk("bad_flush_ready", 32'(alloc_ready), 1);
      // reset in the middle of a rollback
      alloc(30, 5, 45, 2);
      alloc(31, 6, 46, 3);
      alloc(32, 7, 47, 4);
      flush(1);
      chk("abort_rb_active", 32'(restore_phys), 32);
      chk("abort_rb_free", 32'(free_reg), 47);
      #1 rst_n = 0;
      #1;
      chk("abort_free_valid", 32'(free_valid), 0);
      chk("abort_free_reg", 32'(free_reg), 0);
      chk("abort_restore_valid", 32'(restore_valid), 0);
      chk("abort_restore_phys", 32'(restore_phys), 0);
      chk("abort_count", 32'(dut.count), 0);
      #1 rst_n = 1;
      #1;
      chk("abort_alloc_ready", 32'(alloc_ready), 1);
      chk("abort_alloc_tag", 32'(alloc_tag), 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("abort_no_done", 32'(flush_done), 0);
      end
      chk("sb_free_drained", free_q.size(), 0);
      chk("sb_restore_drained", rl_q.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/active_list.md
ACTIVE_LIST -- requirements
Module: active_list

Interface
REQ-001 Parameter DEPTH, 32, number of in-flight entries (power of two).
REQ-002 Parameter PHYS_W, 6, physical register index width.
REQ-003 Parameter LOG_W, 5, logical register index width; TAG_W = log2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 alloc_valid  input  1  rename stage presents a renamed destination.
REQ-007 alloc_ready  output  1  list can accept an entry this cycle.
REQ-008 alloc_prev_phys  input  PHYS_W  physical reg previously mapped to the logical dest.
REQ-009 alloc_logical  input  LOG_W  logical destination register.
REQ-010 alloc_new_phys  input  PHYS_W  newly allocated physical reg.
REQ-011 alloc_tag  output  TAG_W  index the entry is written to (current tail).
REQ-012 complete_valid / complete_tag  input  1 / TAG_W  execution finished for entry tag.
REQ-013 flush_valid / flush_tag  input  1 / TAG_W  mispredict; squash all entries younger than flush_tag.
REQ-014 free_valid / free_reg  output  1 / PHYS_W  physical reg returned to free list.
REQ-015 restore_valid / restore_logical / restore_phys  output  1 / LOG_W / PHYS_W  map-table rollback write.
REQ-016 flush_done  output  1  one-cycle pulse, rollback finished.

Function
REQ-017 Storage: circular buffer of DEPTH entries {valid, done, prev_phys, logical, new_phys}; head, tail pointers wrap mod DEPTH; count 0..DEPTH.
REQ-018 States: NORMAL, ROLLBACK.
REQ-019 alloc_ready = (state==NORMAL) && (count<DEPTH); depends on count only, not on same-cycle commit.
REQ-020 On alloc_valid&&alloc_ready: entry[tail] written valid=1, done=0; tail+1 mod DEPTH; alloc_tag combinationally equals tail.
REQ-021 complete_valid sets entry[complete_tag].done; ignored when entry invalid; repeat completion no effect; accepted in both states.
REQ-022 Commit (NORMAL only): when count>0 and entry[head].done, free_valid=1, free_reg=entry[head].prev_phys combinationally; at edge entry[head] invalidated, head+1.
REQ-023 At most one commit and one alloc per cycle; simultaneous alloc+commit leaves count unchanged.
REQ-024 Completion of head at edge N -> commit visible in cycle N+1 (one-cycle latency).
REQ-025 flush_valid in NORMAL with entry[flush_tag] valid: at edge, state->ROLLBACK, stop tag latched; alloc and commit that cycle still occur.
REQ-026 flush_valid with invalid flush_tag, or while in ROLLBACK: ignored.
REQ-027 ROLLBACK, per cycle while tail-1 != stop tag: restore_valid=1, restore_logical/phys = entry[tail-1].logical/prev_phys; free_valid=1, free_reg=entry[tail-1].new_phys; at edge entry invalidated, tail-1, count-1.
REQ-028 ROLLBACK, when tail-1 == stop tag: no restore/free; flush_done=1 that cycle; state->NORMAL at edge.
REQ-029 Flush of youngest entry: zero rollback cycles; flush_done in first ROLLBACK cycle.
REQ-030 No commit, no alloc in ROLLBACK; flush_tag entry itself never squashed.
REQ-031 All outputs 0 whenever their valid condition is false (except alloc_ready, alloc_tag).

Reset
REQ-032 rst_n low: all entries invalid, done=0, head=tail=count=0, state NORMAL, immediately and asynchronously.
REQ-033 During/after reset: free_valid, restore_valid, flush_done = 0; alloc_ready=1, alloc_tag=0 once rst_n high.
REQ-034 Reset mid-ROLLBACK aborts rollback; no flush_done pulse.

Verification
REQ-035 Alloc {prev=3,log=3,new=32} tag0, complete tag0 -> next cycle free_valid=1, free_reg=3, count 0.
REQ-036 Alloc tags 0,1; complete tag1 only -> no commit; then complete tag0 -> free_reg prev(0) then prev(1) on consecutive cycles.
REQ-037 Fill 32 allocs -> alloc_ready=0 at count 32; commit one -> alloc_ready=1 next cycle, tail wraps to 0.
REQ-038 Allocs tags 0..3 (new 40..43), flush_tag=1 -> restores tag3 then tag2 (free 43, 42), flush_done on 3rd ROLLBACK cycle, count 2.
REQ-039 flush_tag = youngest -> flush_done in first ROLLBACK cycle, no restore_valid.
REQ-040 Assert rst_n low in middle of rollback -> all outputs 0, count 0, alloc_ready=1 after release.
